// File: rtl/qpu_exu_longpwbck.sv
`default_nettype none
// ============================================================================
// Module   : qpu_exu_longpwbck
// Purpose  : Long-pipe write-back stage. Pairs LSU responses with the OITF
//            head and MCU measurement beats with the MOITF head, registers
//            the CRF / MRF write-backs and pops the FIFOs with one-cycle
//            retire pulses.
// Ports    : clk, rst (sync, active-high)
//            LSU response  : lsu_i_valid/ready, lsu_i_rdata
//            OITF head     : oitf_empty, oitf_ret_rdidx, oitf_ret_rdwen,
//                            oitf_ret_ena (pop)
//            CRF write-back: cwbck_o_valid/ready, cwbck_o_data, cwbck_o_rdidx
//            MCU results   : meas_i_valid/ready, meas_i_qubit, meas_i_result
//            MOITF head    : moitf_empty, ret_mf, moitf_ret_ena (pop)
//            MRF write-back: mwbck_o_valid/ready, mwbck_o_data, mwbck_o_mask
//            wbck_err      : sticky protocol error
// Config   : QPU_LONGPWBCK_ERR_EN enables the measurement protocol checker;
//            when undefined wbck_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module qpu_exu_longpwbck #(
    parameter int XLEN      = 32,
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    // LSU response
    input  logic                 lsu_i_valid,
    output logic                 lsu_i_ready,
    input  logic [XLEN-1:0]      lsu_i_rdata,
    // OITF head
    input  logic                 oitf_empty,
    input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
    input  logic                 oitf_ret_rdwen,
    output logic                 oitf_ret_ena,
    // CRF write-back
    output logic                 cwbck_o_valid,
    input  logic                 cwbck_o_ready,
    output logic [XLEN-1:0]      cwbck_o_data,
    output logic [RFIDX_W-1:0]   cwbck_o_rdidx,
    // MCU results
    input  logic                 meas_i_valid,
    output logic                 meas_i_ready,
    input  logic [QUBIT_NUM-1:0] meas_i_qubit,
    input  logic [QUBIT_NUM-1:0] meas_i_result,
    // MOITF head
    input  logic                 moitf_empty,
    input  logic [QUBIT_NUM-1:0] ret_mf,
    output logic                 moitf_ret_ena,
    // MRF write-back
    output logic                 mwbck_o_valid,
    input  logic                 mwbck_o_ready,
    output logic [QUBIT_NUM-1:0] mwbck_o_data,
    output logic [QUBIT_NUM-1:0] mwbck_o_mask,
    // Sticky error
    output logic                 wbck_err
);

    localparam logic [1:0] M_IDLE    = 2'd0;
    localparam logic [1:0] M_COLLECT = 2'd1;
    localparam logic [1:0] M_WB      = 2'd2;

    // ------------------------------------------------------------------
    // Classical channel
    // ------------------------------------------------------------------
    logic                r_c_vld;
    logic [XLEN-1:0]     r_c_data;
    logic [RFIDX_W-1:0]  r_c_rdidx;
    logic                w_c_hs;

    // Ready is masked during reset so nothing is accepted or retired in a
    // cycle whose state update is being discarded.
    assign lsu_i_ready  = ~rst & ~oitf_empty & (~r_c_vld | cwbck_o_ready);
    assign w_c_hs       = lsu_i_valid & lsu_i_ready;
    assign oitf_ret_ena = w_c_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_vld   <= 1'b0;
            r_c_data  <= '0;
            r_c_rdidx <= '0;
        end else if (w_c_hs) begin
            // A handshake implies any held entry is leaving this cycle,
            // so a store simply leaves the register empty.
            r_c_vld <= oitf_ret_rdwen;
            if (oitf_ret_rdwen) begin
                r_c_data  <= lsu_i_rdata;
                r_c_rdidx <= oitf_ret_rdidx;
            end
        end else if (cwbck_o_ready) begin
            r_c_vld <= 1'b0;
        end
    end

    assign cwbck_o_valid = r_c_vld;
    assign cwbck_o_data  = r_c_data;
    assign cwbck_o_rdidx = r_c_rdidx;

    // ------------------------------------------------------------------
    // Measurement channel
    // ------------------------------------------------------------------
    logic [1:0]           r_m_state;
    logic [QUBIT_NUM-1:0] r_acc_got;
    logic [QUBIT_NUM-1:0] r_acc_res;
    logic [QUBIT_NUM-1:0] r_m_data;
    logic [QUBIT_NUM-1:0] r_m_mask;
    logic                 w_m_hs;
    logic [QUBIT_NUM-1:0] w_m_new;
    logic [QUBIT_NUM-1:0] w_got_n;
    logic [QUBIT_NUM-1:0] w_res_n;
    logic                 w_m_done;

    assign meas_i_ready = ~rst & ~moitf_empty & (r_m_state != M_WB);
    assign w_m_hs       = meas_i_valid & meas_i_ready;

    // Only qubits on the head's measure list are taken; a repeated report
    // of an already collected qubit overwrites the earlier value.
    assign w_m_new  = meas_i_qubit & ret_mf;
    assign w_got_n  = r_acc_got | w_m_new;
    assign w_res_n  = (r_acc_res & ~w_m_new) | (meas_i_result & w_m_new);
    assign w_m_done = ((w_got_n & ret_mf) == ret_mf);

    assign moitf_ret_ena = w_m_hs & w_m_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_state <= M_IDLE;
            r_acc_got <= '0;
            r_acc_res <= '0;
            r_m_data  <= '0;
            r_m_mask  <= '0;
        end else begin
            case (r_m_state)
                M_IDLE, M_COLLECT: begin
                    if (w_m_hs) begin
                        if (w_m_done) begin
                            r_m_data  <= w_res_n & ret_mf;
                            r_m_mask  <= ret_mf;
                            r_acc_got <= '0;
                            r_acc_res <= '0;
                            r_m_state <= M_WB;
                        end else begin
                            r_acc_got <= w_got_n;
                            r_acc_res <= w_res_n;
                            r_m_state <= M_COLLECT;
                        end
                    end
                end
                M_WB: begin
                    if (mwbck_o_ready) begin
                        r_m_state <= M_IDLE;
                    end
                end
                default: r_m_state <= M_IDLE;
            endcase
        end
    end

    assign mwbck_o_valid = (r_m_state == M_WB);
    assign mwbck_o_data  = r_m_data;
    assign mwbck_o_mask  = r_m_mask;

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef QPU_LONGPWBCK_ERR_EN
    logic r_err;
    logic w_bad;

    // Out-of-list qubits or an empty qubit vector on an accepted beat.
    assign w_bad = w_m_hs & ((|(meas_i_qubit & ~ret_mf)) | ~(|meas_i_qubit));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign wbck_err = r_err;
`else
    assign wbck_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qpu_exu_longpwbck.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpu_exu_longpwbck
// Purpose  : Directed self-checking bench for qpu_exu_longpwbck. A per-qubit
//            transaction model predicts every output on each falling edge;
//            literal expectations pin the model at the test-plan points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpu_exu_longpwbck;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_i_valid, lsu_i_ready;
    logic [31:0] lsu_i_rdata;
    logic        oitf_empty;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen, oitf_ret_ena;
    logic        cwbck_o_valid, cwbck_o_ready;
    logic [31:0] cwbck_o_data;
    logic [4:0]  cwbck_o_rdidx;
    logic        meas_i_valid, meas_i_ready;
    logic [7:0]  meas_i_qubit, meas_i_result;
    logic        moitf_empty;
    logic [7:0]  ret_mf;
    logic        moitf_ret_ena;
    logic        mwbck_o_valid, mwbck_o_ready;
    logic [7:0]  mwbck_o_data, mwbck_o_mask;
    logic        wbck_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qpu_exu_longpwbck #(.XLEN(32), .RFIDX_W(5), .QUBIT_NUM(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_i_valid(lsu_i_valid), .lsu_i_ready(lsu_i_ready), .lsu_i_rdata(lsu_i_rdata),
        .oitf_empty(oitf_empty), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_ena(oitf_ret_ena),
        .cwbck_o_valid(cwbck_o_valid), .cwbck_o_ready(cwbck_o_ready),
        .cwbck_o_data(cwbck_o_data), .cwbck_o_rdidx(cwbck_o_rdidx),
        .meas_i_valid(meas_i_valid), .meas_i_ready(meas_i_ready),
        .meas_i_qubit(meas_i_qubit), .meas_i_result(meas_i_result),
        .moitf_empty(moitf_empty), .ret_mf(ret_mf), .moitf_ret_ena(moitf_ret_ena),
        .mwbck_o_valid(mwbck_o_valid), .mwbck_o_ready(mwbck_o_ready),
        .mwbck_o_data(mwbck_o_data), .mwbck_o_mask(mwbck_o_mask),
        .wbck_err(wbck_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one pending CRF entry, one pending MRF entry and
    // per-qubit "collected" / "value" flags for the MOITF head.
    // ------------------------------------------------------------------
    bit          mc_pend;
    logic [31:0] mc_data;
    logic [4:0]  mc_idx;
    bit          mm_pend;
    bit          mg [8];
    bit          mr [8];
    logic [7:0]  mm_data, mm_mask;
    bit          m_err;

    function automatic bit beat_completes();
        for (int q = 0; q < 8; q++)
            if (ret_mf[q] && !mg[q] && !meas_i_qubit[q]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mc_pend = 0; mm_pend = 0; m_err = 0;
            for (int q = 0; q < 8; q++) begin mg[q] = 0; mr[q] = 0; end
        end else begin
            if (lsu_i_valid && !oitf_empty && (!mc_pend || cwbck_o_ready)) begin
                mc_pend = oitf_ret_rdwen;
                if (oitf_ret_rdwen) begin mc_data = lsu_i_rdata; mc_idx = oitf_ret_rdidx; end
            end else if (cwbck_o_ready) begin
                mc_pend = 0;
            end
            if (mm_pend) begin
                if (mwbck_o_ready) mm_pend = 0;
            end else if (meas_i_valid && !moitf_empty) begin
                bit done;
                done = beat_completes();
`ifdef QPU_LONGPWBCK_ERR_EN
                if (meas_i_qubit == 8'h00) m_err = 1;
                for (int q = 0; q < 8; q++) if (meas_i_qubit[q] && !ret_mf[q]) m_err = 1;
`endif
                for (int q = 0; q < 8; q++)
                    if (ret_mf[q] && meas_i_qubit[q]) begin mg[q] = 1; mr[q] = meas_i_result[q]; end
                if (done) begin
                    mm_pend = 1;
                    mm_mask = ret_mf;
                    for (int q = 0; q < 8; q++) begin
                        mm_data[q] = ret_mf[q] ? mr[q] : 1'b0;
                        mg[q] = 0; mr[q] = 0;
                    end
                end
            end
        end
    end

    bit run_chk = 0;
    always @(negedge clk) begin
        if (run_chk) begin
            bit exp_lr, exp_mr;
            exp_lr = !rst && !oitf_empty && (!mc_pend || cwbck_o_ready);
            exp_mr = !rst && !moitf_empty && !mm_pend;
            chk("m_lsu_ready", {31'd0, lsu_i_ready}, {31'd0, exp_lr});
            chk("m_oitf_ret", {31'd0, oitf_ret_ena}, {31'd0, exp_lr && lsu_i_valid});
            chk("m_cwb_valid", {31'd0, cwbck_o_valid}, {31'd0, mc_pend});
            if (mc_pend) begin
                chk("m_cwb_data", cwbck_o_data, mc_data);
                chk("m_cwb_idx", {27'd0, cwbck_o_rdidx}, {27'd0, mc_idx});
            end
            chk("m_meas_ready", {31'd0, meas_i_ready}, {31'd0, exp_mr});
            chk("m_moitf_ret", {31'd0, moitf_ret_ena},
                {31'd0, exp_mr && meas_i_valid && beat_completes()});
            chk("m_mwb_valid", {31'd0, mwbck_o_valid}, {31'd0, mm_pend});
            if (mm_pend) begin
                chk("m_mwb_data", {24'd0, mwbck_o_data}, {24'd0, mm_data});
                chk("m_mwb_mask", {24'd0, mwbck_o_mask}, {24'd0, mm_mask});
            end
            chk("m_err", {31'd0, wbck_err}, {31'd0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] qb, input logic [7:0] res);
        meas_i_valid = 1; meas_i_qubit = qb; meas_i_result = res;
    endtask

    initial begin
        rst = 1; lsu_i_valid = 0; lsu_i_rdata = 0; oitf_empty = 1;
        oitf_ret_rdidx = 0; oitf_ret_rdwen = 0; cwbck_o_ready = 1;
        meas_i_valid = 0; meas_i_qubit = 0; meas_i_result = 0;
        moitf_empty = 1; ret_mf = 0; mwbck_o_ready = 1;
        step(); step();
        rst = 0;
        run_chk = 1;
        @(negedge clk);
        chk("rst_cwb_valid", {31'd0, cwbck_o_valid}, 0);
        chk("rst_cwb_data", cwbck_o_data, 0);
        chk("rst_cwb_idx", {27'd0, cwbck_o_rdidx}, 0);
        chk("rst_mwb_valid", {31'd0, mwbck_o_valid}, 0);
        chk("rst_mwb_data", {24'd0, mwbck_o_data}, 0);
        chk("rst_mwb_mask", {24'd0, mwbck_o_mask}, 0);
        chk("rst_err", {31'd0, wbck_err}, 0);
        // Responses while FIFOs are empty must not be taken
        step(); lsu_i_valid = 1; beat(8'h01, 8'h01); ret_mf = 8'h01;
        @(negedge clk);
        chk("empty_lsu_ready", {31'd0, lsu_i_ready}, 0);
        chk("empty_meas_ready", {31'd0, meas_i_ready}, 0);
        chk("empty_oitf_ret", {31'd0, oitf_ret_ena}, 0);
        meas_i_valid = 0;

        // Load
        step(); oitf_empty = 0; oitf_ret_rdidx = 5; oitf_ret_rdwen = 1;
        lsu_i_rdata = 32'hDEADBEEF; lsu_i_valid = 1;
        @(negedge clk);
        chk("load_ret", {31'd0, oitf_ret_ena}, 1);
        step(); lsu_i_valid = 0;
        @(negedge clk);
        chk("load_valid", {31'd0, cwbck_o_valid}, 1);
        chk("load_idx", {27'd0, cwbck_o_rdidx}, 5);
        chk("load_data", cwbck_o_data, 32'hDEADBEEF);

        // Store
        step(); oitf_ret_rdwen = 0; lsu_i_valid = 1; lsu_i_rdata = 32'h11111111;
        @(negedge clk);
        chk("store_ret", {31'd0, oitf_ret_ena}, 1);
        step(); lsu_i_valid = 0;
        @(negedge clk);
        chk("store_novalid", {31'd0, cwbck_o_valid}, 0);

        // Backpressure
        step(); cwbck_o_ready = 0; oitf_ret_rdwen = 1; oitf_ret_rdidx = 3;
        lsu_i_rdata = 32'h00001234; lsu_i_valid = 1;
        step(); oitf_ret_rdidx = 7; lsu_i_rdata = 32'h00005678;
        @(negedge clk);
        chk("bp_ready", {31'd0, lsu_i_ready}, 0);
        chk("bp_ret", {31'd0, oitf_ret_ena}, 0);
        chk("bp_held", cwbck_o_data, 32'h00001234);
        step();
        step(); cwbck_o_ready = 1;
        @(negedge clk);
        chk("bp_release", {31'd0, oitf_ret_ena}, 1);
        // Back-to-back loads at full rate
        for (int i = 0; i < 4; i++) begin
            step(); oitf_ret_rdidx = 5'(10 + i); lsu_i_rdata = 32'hA0000000 + 32'(i);
            oitf_ret_rdwen = (i != 2);
        end
        step(); lsu_i_valid = 0; oitf_empty = 1;

        // Split measurement
        step(); moitf_empty = 0; ret_mf = 8'h0C; beat(8'h04, 8'h04);
        @(negedge clk);
        chk("split_b1_noret", {31'd0, moitf_ret_ena}, 0);
        step(); beat(8'h08, 8'h00); mwbck_o_ready = 0;
        @(negedge clk);
        chk("split_b2_ret", {31'd0, moitf_ret_ena}, 1);
        step();
        @(negedge clk);
        chk("split_valid", {31'd0, mwbck_o_valid}, 1);
        chk("split_mask", {24'd0, mwbck_o_mask}, 32'h0C);
        chk("split_data", {24'd0, mwbck_o_data}, 32'h04);
        chk("split_wb_noready", {31'd0, meas_i_ready}, 0);
        step(); mwbck_o_ready = 1; meas_i_valid = 0;

        // Overwrite of an already collected qubit
        step(); ret_mf = 8'h03; beat(8'h01, 8'h01);
        step(); beat(8'h01, 8'h00);
        step(); beat(8'h02, 8'h02);
        step(); meas_i_valid = 0;
        @(negedge clk);
        chk("ovw_data", {24'd0, mwbck_o_data}, 32'h02);

        // Out-of-list qubit bits
        step(); ret_mf = 8'h01; beat(8'h03, 8'h03);
        @(negedge clk);
        chk("oob_ret", {31'd0, moitf_ret_ena}, 1);
        step(); meas_i_valid = 0;
        @(negedge clk);
        chk("oob_data", {24'd0, mwbck_o_data}, 32'h01);
`ifdef QPU_LONGPWBCK_ERR_EN
        chk("oob_err", {31'd0, wbck_err}, 1);
        step(); step();
        chk("oob_err_sticky", {31'd0, wbck_err}, 1);
`else
        chk("oob_err", {31'd0, wbck_err}, 0);
`endif

        // Reset mid-collect
        step(); ret_mf = 8'h0C; beat(8'h04, 8'h04);
        step(); meas_i_valid = 0; rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("rstc_mwb_valid", {31'd0, mwbck_o_valid}, 0);
        chk("rstc_err", {31'd0, wbck_err}, 0);
        beat(8'h08, 8'h00);
        @(negedge clk);
        chk("rstc_partial_noret", {31'd0, moitf_ret_ena}, 0);
        step(); meas_i_valid = 0;
        step(); step(); ret_mf = 8'h04; beat(8'h04, 8'h00);
        step(); meas_i_valid = 0;
        // The lone 0x08 beat was kept; a full 0x0C entry must start over
        step(); step(); ret_mf = 8'h0C; beat(8'h0C, 8'h08);
        @(negedge clk);
        chk("rstc_full_ret", {31'd0, moitf_ret_ena}, 1);
        step(); meas_i_valid = 0;
        @(negedge clk);
        chk("rstc_data", {24'd0, mwbck_o_data}, 32'h08);

        // Both channels retire in the same cycle
        step(); oitf_empty = 0; oitf_ret_rdwen = 1; oitf_ret_rdidx = 9;
        lsu_i_rdata = 32'hCAFEF00D; lsu_i_valid = 1;
        ret_mf = 8'hF0; beat(8'hF0, 8'h50);
        @(negedge clk);
        chk("both_oitf_ret", {31'd0, oitf_ret_ena}, 1);
        chk("both_moitf_ret", {31'd0, moitf_ret_ena}, 1);
        step(); lsu_i_valid = 0; meas_i_valid = 0;
        @(negedge clk);
        chk("both_cdata", cwbck_o_data, 32'hCAFEF00D);
        chk("both_mdata", {24'd0, mwbck_o_data}, 32'h50);
        step(); step();
        run_chk = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/qpu_exu_longpwbck.md
# qpu_exu_longpwbck

Long-pipe write-back stage that sits directly downstream of the outstanding-instruction track FIFOs (OITF for classical long-pipe ops, MOITF for measurements). It consumes LSU load/store responses and measurement-control-unit (MCU) qubit results, pairs each with the entry at the head of the matching FIFO, registers the write-back toward the classical register file (CRF) and measurement result register (MRF), and issues the one-cycle retire pulses (`oitf_ret_ena`, `moitf_ret_ena`) that pop those FIFOs.

## Interface
- `XLEN`, 32, classical data width
- `RFIDX_W`, 5, register index width
- `QUBIT_NUM`, 8, qubits covered by one measurement entry

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `lsu_i_valid` / `lsu_i_ready`  in / out  1  LSU response handshake
- `lsu_i_rdata`  in  XLEN  LSU response data
- `oitf_empty`  in  1  OITF has no entry
- `oitf_ret_rdidx`  in  RFIDX_W  OITF head destination index
- `oitf_ret_rdwen`  in  1  OITF head writes a register
- `oitf_ret_ena`  out  1  pop OITF head
- `cwbck_o_valid` / `cwbck_o_ready`  out / in  1  CRF write-back handshake
- `cwbck_o_data`  out  XLEN; `cwbck_o_rdidx`  out  RFIDX_W
- `meas_i_valid` / `meas_i_ready`  in / out  1  MCU result handshake
- `meas_i_qubit`  in  QUBIT_NUM  qubits reported this beat
- `meas_i_result`  in  QUBIT_NUM  result bits (valid where `meas_i_qubit`=1)
- `moitf_empty`  in  1  MOITF has no entry
- `ret_mf`  in  QUBIT_NUM  MOITF head measure list
- `moitf_ret_ena`  out  1  pop MOITF head
- `mwbck_o_valid` / `mwbck_o_ready`  out / in  1  MRF write-back handshake
- `mwbck_o_data`  out  QUBIT_NUM; `mwbck_o_mask`  out  QUBIT_NUM
- `wbck_err`  out  1  sticky protocol error (see Configuration)

## Operation
- Classical channel, single output register `c_vld`:
  - `lsu_i_ready = !oitf_empty & (!c_vld | cwbck_o_ready)`.
  - On `lsu_i_valid & lsu_i_ready`: `oitf_ret_ena`=1 same cycle (combinational). If `oitf_ret_rdwen`, load `cwbck_o_data`←`lsu_i_rdata`, `cwbck_o_rdidx`←`oitf_ret_rdidx`, `c_vld`←1; else (store) retire only, `c_vld`←0 unless previous still held.
  - `c_vld` clears on `cwbck_o_ready` with no new load.
- Measurement channel, FSM `M_IDLE`, `M_COLLECT`, `M_WB`; registers `acc_got`, `acc_res` (QUBIT_NUM each).
  - `meas_i_ready = !moitf_empty & (state != M_WB)`.
  - Accepted beat: `got_n = acc_got | (meas_i_qubit & ret_mf)`; `acc_res` bits under that mask ← `meas_i_result`.
  - If `(got_n & ret_mf) == ret_mf`: `moitf_ret_ena`=1 same cycle, `mwbck_o_data`←merged result & `ret_mf`, `mwbck_o_mask`←`ret_mf`, clear acc, → `M_WB`. Else → `M_COLLECT`.
  - `M_WB` → `M_IDLE` on `mwbck_o_ready`. `mwbck_o_valid` = (state == `M_WB`).
  - Qubit already in `acc_got` reported again: newer value overwrites.
- Channels independent; both may retire in the same cycle.

## Timing
- Reset values: `c_vld`=0, state=`M_IDLE`, acc=0, all data outputs 0, `wbck_err`=0; ready/ret outputs follow combinational rules (0 while FIFOs empty).
- Classical latency: response accept → `cwbck_o_valid` next cycle; full throughput 1/cycle with `cwbck_o_ready` held high.
- Measurement latency: completing beat → `mwbck_o_valid` next cycle; minimum 2 cycles per entry (no accept in `M_WB`).
- Response while FIFO empty: not accepted (ready low), held by producer.
- `rst` mid-operation: partial accumulation and pending write-backs discarded, no retire pulse that cycle.

## Configuration
- `QPU_LONGPWBCK_ERR_EN` defined: `wbck_err` set (sticky until `rst`) when an accepted MCU beat has `meas_i_qubit & ~ret_mf` nonzero, or `meas_i_qubit`=0; offending bits ignored.
- Undefined: checking logic absent, `wbck_err` tied 0; out-of-list bits silently ignored.

## Test plan
- Load: OITF head rdidx=5, rdwen=1, LSU rdata=0xDEADBEEF → `oitf_ret_ena` pulse cycle N, `cwbck_o_valid` rdidx=5 data=0xDEADBEEF cycle N+1.
- Store: rdwen=0 → `oitf_ret_ena` pulse, `cwbck_o_valid` stays 0.
- Backpressure: `cwbck_o_ready`=0 with `c_vld`=1 → `lsu_i_ready`=0, no retire until ready returns.
- Split measurement: `ret_mf`=0x0C, beat1 qubit=0x04 result=0x04, beat2 qubit=0x08 result=0x00 → retire on beat2, `mwbck_o_mask`=0x0C, data=0x04.
- Error (ERR_EN): `ret_mf`=0x01, beat qubit=0x03 result=0x03 → retire, data=0x01, `wbck_err`=1 until `rst`.
- Reset mid-collect: after beat1 above, `rst` pulse → acc cleared, `mwbck_o_valid`=0, new full beat 0x0C required to retire.
